// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 datapath widths and types
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with x0 masking and write-through bypass
module regfile_read_port
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH],
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] data
);
    always_comb
        data = (addr == '0) ? '0 :
               (BYPASS_EN && we && !rst && wa == addr) ? wd : regs[addr];
endmodule

// File: rtl/register_file.sv
// register_file: 32 x 32-bit integer register file, two async read ports, one sync write port
module register_file
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] ADRS1,
    input  logic [ADDR_WIDTH-1:0] ADRS2,
    input  logic [ADDR_WIDTH-1:0] WB_ADDRESS,
    input  logic                  WRITE_ENABLE,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic [DATA_WIDTH-1:0] DATA_OUT1,
    output logic [DATA_WIDTH-1:0] DATA_OUT2
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    always_ff @(posedge CLK)
        if (RESET)
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        else if (WRITE_ENABLE && WB_ADDRESS != '0)
            regs[WB_ADDRESS] <= WRITE_DATA;
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS_EN(BYPASS_EN)) u_rp1 (
        .addr(ADRS1), .regs(regs), .rst(RESET), .we(WRITE_ENABLE),
        .wa(WB_ADDRESS), .wd(WRITE_DATA), .data(DATA_OUT1)
    );
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BYPASS_EN(BYPASS_EN)) u_rp2 (
        .addr(ADRS2), .regs(regs), .rst(RESET), .we(WRITE_ENABLE),
        .wa(WB_ADDRESS), .wd(WRITE_DATA), .data(DATA_OUT2)
    );
`ifndef SYNTHESIS
    task automatic print_registers();
        for (int i = 0; i < DEPTH; i++) $display("x%0d: %h", i, regs[i]);
    endtask
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scoreboard bench for register_file
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a1, a2, wa;
    logic        we;
    logic [31:0] wd, d1, d2;
    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        bit          port;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    register_file dut (
        .CLK(clk), .RESET(rst), .ADRS1(a1), .ADRS2(a2), .WB_ADDRESS(wa),
        .WRITE_ENABLE(we), .WRITE_DATA(wd), .DATA_OUT1(d1), .DATA_OUT2(d2)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input bit port, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.port = port;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = e.port ? d2 : d1;
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; a1 = '0; a2 = '0;
        repeat (2) @(posedge clk);
        // reset state
        @(negedge clk); rst = 1'b0; a1 = 5'd1; a2 = 5'd2;
        push("reset_x1", 0, 32'h0); push("reset_x2", 1, 32'h0);
        #1 drain();
        // write x15 with bypass before the edge
        @(negedge clk); we = 1'b1; wa = 5'd15; wd = 32'hAAAA_AAAA; a1 = 5'd15;
        push("x15_bypass", 0, 32'hAAAA_AAAA);
        #1 drain();
        @(negedge clk); we = 1'b0; wd = 32'h0;
        push("x15_stored", 0, 32'hAAAA_AAAA);
        #1 drain();
        // write to x0 is discarded and never bypassed
        @(negedge clk); we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; a1 = 5'd0; a2 = 5'd15;
        push("x0_pre", 0, 32'h0); push("x15_p2", 1, 32'hAAAA_AAAA);
        #1 drain();
        @(negedge clk); we = 1'b0;
        push("x0_post", 0, 32'h0);
        #1 drain();
        // back-to-back writes x20, x21
        @(negedge clk); we = 1'b1; wa = 5'd20; wd = 32'h1234_5678;
        @(negedge clk); wa = 5'd21; wd = 32'h8765_4321; a1 = 5'd20; a2 = 5'd21;
        push("x20_stored", 0, 32'h1234_5678); push("x21_bypass", 1, 32'h8765_4321);
        #1 drain();
        @(negedge clk); we = 1'b0;
        push("x20_read", 0, 32'h1234_5678); push("x21_read", 1, 32'h8765_4321);
        #1 drain();
        // both ports on the write target
        @(negedge clk); we = 1'b1; wa = 5'd21; wd = 32'hCAFE_F00D; a1 = 5'd21; a2 = 5'd21;
        push("dual_bp1", 0, 32'hCAFE_F00D); push("dual_bp2", 1, 32'hCAFE_F00D);
        #1 drain();
        @(negedge clk); we = 1'b0;
        push("dual_rd1", 0, 32'hCAFE_F00D); push("dual_rd2", 1, 32'hCAFE_F00D);
        #1 drain();
        // WE=0 writes nothing and does not bypass
        @(negedge clk); wa = 5'd25; wd = 32'hDEAD_BEEF; a1 = 5'd25; a2 = 5'd20;
        push("we0_pre", 0, 32'h0); push("x20_keep", 1, 32'h1234_5678);
        #1 drain();
        @(negedge clk);
        push("we0_post", 0, 32'h0);
        #1 drain();
        // reset beats a same-cycle write; bypass suppressed during reset
        @(negedge clk); rst = 1'b1; we = 1'b1; wa = 5'd15; wd = 32'h5555_5555; a1 = 5'd15; a2 = 5'd20;
        push("rst_nobp", 0, 32'hAAAA_AAAA); push("rst_x20_pre", 1, 32'h1234_5678);
        #1 drain();
        @(negedge clk); rst = 1'b0; we = 1'b0;
        push("rst_x15", 0, 32'h0); push("rst_x20", 1, 32'h0);
        #1 drain();
        dut.print_registers();
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            push($sformatf("clr_p1_x%0d", i), 0, 32'h0);
            push($sformatf("clr_p2_x%0d", 31 - i), 1, 32'h0);
            #1 drain();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
